apb_reg_bridge: RTL and testbench

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

---
 rtl/reg_bridge_pkg.sv | 26 ++
 rtl/reg_timeout_cnt.sv | 29 ++
 rtl/apb_reg_bridge.sv | 145 ++++++++++++++
 tb/tb_apb_reg_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bridge_pkg.sv
// Shared definitions for the APB-to-register-FSM bridge: state encoding,
// default widths and the timeout counter sizing helper.
package reg_bridge_pkg;

    localparam int DEF_ADDR_WIDTH     = 64;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    // Smallest counter width that can hold max_val (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while (w < 31 && (1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_timeout_cnt.sv
// Transaction watchdog: counts while enabled, flags when the count equals a
// non-zero threshold and then holds there until cleared.
module reg_timeout_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] threshold,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // A zero threshold never matches, which disables the watchdog.
    assign expired = (threshold != '0) && (cnt == threshold);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB slave that forwards each transfer as a valid/ready request to a register
// FSM and returns its acknowledge (or a timeout error) as the APB response.
module apb_reg_bridge
    import reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mst__fsm__req_vld,
    output logic                  mst__fsm__rd_en,
    output logic                  mst__fsm__wr_en,
    output logic [ADDR_WIDTH-1:0] mst__fsm__addr,
    output logic [DATA_WIDTH-1:0] mst__fsm__wr_data,
    output logic                  mst__fsm__sync_reset,
    output logic                  mst__fsm__ack_rdy,
    input  logic                  fsm__mst__req_rdy,
    input  logic                  fsm__mst__ack_vld,
    input  logic [DATA_WIDTH-1:0] fsm__mst__rd_data,
    output logic [1:0]            dbg_state
);

    // Handshakes: the request transfers on a cycle with req_vld && req_rdy;
    // the ack transfers on a cycle with ack_vld && ack_rdy. Within S_REQ an
    // ack counts only together with req_rdy.

    localparam int               CNT_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(TIMEOUT_CYCLES);

    state_e state, state_nxt;
    logic   setup;
    logic   ack_take;
    logic   tmo_hit;
    logic   expired;
    logic   pwrite_q;
    logic   err_q;
    logic   sync_q;

    assign setup = psel && !penable;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_take  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (fsm__mst__req_rdy && fsm__mst__ack_vld) begin
                    ack_take  = 1'b1;
                    state_nxt = S_RESP;
                end else if (expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_RESP;
                end else if (fsm__mst__req_rdy) begin
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // An ack landing on the expiry cycle still wins over the abort.
                if (fsm__mst__ack_vld) begin
                    ack_take  = 1'b1;
                    state_nxt = S_RESP;
                end else if (expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mst__fsm__addr    <= '0;
            mst__fsm__wr_data <= '0;
            pwrite_q          <= 1'b0;
            prdata            <= '0;
            err_q             <= 1'b0;
            sync_q            <= 1'b0;
        end else begin
            if (state == S_IDLE && setup) begin
                mst__fsm__addr    <= paddr;
                mst__fsm__wr_data <= pwdata;
                pwrite_q          <= pwrite;
            end
            if (ack_take) begin
                prdata <= pwrite_q ? '0 : fsm__mst__rd_data;
                err_q  <= 1'b0;
            end else if (tmo_hit) begin
                prdata <= '0;
                err_q  <= 1'b1;
            end
            // The abort pulse lines up with the erroring pready cycle.
            sync_q <= tmo_hit;
        end
    end

    reg_timeout_cnt #(
        .CNT_W(CNT_W)
    ) u_timeout_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (state == S_IDLE),
        .enable   ((state == S_REQ) || (state == S_WAIT_ACK)),
        .threshold(THRESH),
        .expired  (expired)
    );

    assign mst__fsm__req_vld    = (state == S_REQ);
    assign mst__fsm__rd_en      = mst__fsm__req_vld && !pwrite_q;
    assign mst__fsm__wr_en      = mst__fsm__req_vld && pwrite_q;
    assign mst__fsm__ack_rdy    = (state == S_REQ) || (state == S_WAIT_ACK);
    assign mst__fsm__sync_reset = sync_q;
    assign pready               = (state == S_RESP);
    assign pslverr              = pready && err_q;
    assign dbg_state            = state;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Randomized bench for apb_reg_bridge: APB driver tasks, a slave-FSM responder,
// and a response scoreboard fed from a cycle-level model of each transfer.
module tb_apb_reg_bridge;
    import reg_bridge_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int T  = 8;

    logic          clk;
    logic          rstn;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          req_vld;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;
    logic          sync_reset;
    logic          ack_rdy;
    logic          req_rdy;
    logic          ack_vld;
    logic [DW-1:0] rd_data;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int n_txn  = 0;
    int pulses = 0;
    logic prev_pready = 1'b0;
    logic [DW:0] exp_q[$];

    apb_reg_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .psel                (psel),
        .penable             (penable),
        .pwrite              (pwrite),
        .paddr               (paddr),
        .pwdata              (pwdata),
        .prdata              (prdata),
        .pready              (pready),
        .pslverr             (pslverr),
        .mst__fsm__req_vld   (req_vld),
        .mst__fsm__rd_en     (rd_en),
        .mst__fsm__wr_en     (wr_en),
        .mst__fsm__addr      (f_addr),
        .mst__fsm__wr_data   (f_wdata),
        .mst__fsm__sync_reset(sync_reset),
        .mst__fsm__ack_rdy   (ack_rdy),
        .fsm__mst__req_rdy   (req_rdy),
        .fsm__mst__ack_vld   (ack_vld),
        .fsm__mst__rd_data   (rd_data),
        .dbg_state           (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prdata"},  prdata, 0);
        check({tag, "_pready"},  pready, 0);
        check({tag, "_pslverr"}, pslverr, 0);
        check({tag, "_req_vld"}, req_vld, 0);
        check({tag, "_rd_en"},   rd_en, 0);
        check({tag, "_wr_en"},   wr_en, 0);
        check({tag, "_addr"},    f_addr, 0);
        check({tag, "_wr_data"}, f_wdata, 0);
        check({tag, "_sync"},    sync_reset, 0);
        check({tag, "_ack_rdy"}, ack_rdy, 0);
        check({tag, "_state"},   dbg_state, S_IDLE);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        @(posedge clk); #1;
        psel = 0; penable = 0; req_rdy = 0; ack_vld = 0;
        repeat (n - 1) @(posedge clk);
    endtask

    // One APB transfer. The slave raises req_rdy rd cycles after the first
    // request cycle and ack_vld ad cycles after it (ad >= rd). The watchdog
    // reaches T on relative cycle T, so the ack wins iff ad <= T.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rdat, input int rd, input int ad, input bit drop_psel);
        bit tmo;
        bit seen;
        int pr_cyc;
        int lim;
        bit vld_exp;
        tmo    = (T != 0) && (ad > T);
        pr_cyc = 2 + (tmo ? T : ad);
        lim    = (rd < T) ? rd : T;
        exp_q.push_back({tmo, (wr || tmo) ? {DW{1'b0}} : rdat});
        n_txn++;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
        req_rdy = 0; ack_vld = 0; rd_data = 0;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            penable = 1;
            if (drop_psel && c >= 2) begin
                psel = 0; penable = 0;
                pwrite = 1'($urandom); paddr = {$urandom, $urandom}; pwdata = $urandom;
            end
            req_rdy = (c - 1 >= rd);
            ack_vld = (c - 1 >= ad);
            rd_data = ack_vld ? rdat : $urandom;
            @(negedge clk);
            if (pready) begin
                seen = 1;
                check("pready_latency", c, pr_cyc);
            end
            vld_exp = (c < pr_cyc) && (c - 1 <= lim);
            check("req_vld",   req_vld, vld_exp);
            check("rd_en",     rd_en, vld_exp && !wr);
            check("wr_en",     wr_en, vld_exp && wr);
            check("ack_rdy",   ack_rdy, c < pr_cyc);
            check("sync_reset", sync_reset, tmo && (c == pr_cyc));
            check("latched_addr",  f_addr, a);
            check("latched_wdata", f_wdata, wd);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL pready_timeout: no pready within 40 cycles for addr %0h", a);
        end
    endtask

    // Abandon a read in S_WAIT_ACK by pulling reset.
    task automatic reset_mid_txn();
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 64'h5000; pwdata = 32'h0;
        req_rdy = 0; ack_vld = 0;
        @(posedge clk); #1;
        penable = 1; req_rdy = 1;
        @(posedge clk); #1;
        req_rdy = 0;
        @(negedge clk);
        check("wait_state",   dbg_state, S_WAIT_ACK);
        check("wait_req_vld", req_vld, 0);
        check("wait_ack_rdy", ack_rdy, 1);
        @(posedge clk); #1;
        rstn = 0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        psel = 0; penable = 0;
        rstn = 1;
        repeat (3) @(posedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rstn) begin
            prev_pready = 1'b0;
        end else begin
            if (pready) begin
                pulses++;
                check("pready_single_cycle", prev_pready, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pready: prdata=%0h pslverr=%0b with no transfer pending", prdata, pslverr);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_prdata",  prdata, e[DW-1:0]);
                    check("resp_pslverr", pslverr, e[DW]);
                end
            end
            prev_pready = pready;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        req_rdy = 0; ack_vld = 0; rd_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rstn = 1;
        @(posedge clk);

        // single-cycle write
        run_txn(1, 64'h1000, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        idle(2);
        // read with delayed request accept and later ack
        run_txn(0, 64'h2004, 32'h0, 32'h12345678, 3, 5, 0);
        idle(2);
        // no ack in time; the ack arrives in the response cycle and is ignored
        run_txn(0, 64'h2008, 32'h0, 32'hCAFEF00D, 0, 9, 0);
        idle(2);
        // ack on the expiry cycle wins
        run_txn(0, 64'h200C, 32'h0, 32'hA5A50043, 0, 8, 0);
        // timeout while still waiting for req_rdy
        run_txn(1, 64'h2010, 32'h0BAD0BAD, 32'h0, 10, 10, 0);
        run_txn(0, 64'h2014, 32'h0, 32'h00C0FFEE, 1, 1, 0);
        reset_mid_txn();
        run_txn(0, 64'h5004, 32'h0, 32'h600DD00D, 1, 2, 0);
        // back-to-back writes
        run_txn(1, 64'h3000, 32'h11110001, 32'h0, 0, 0, 0);
        run_txn(1, 64'h3008, 32'h22220002, 32'h0, 1, 2, 0);
        idle(1);
        // psel dropped during the transfer, bus inputs scrambled
        run_txn(0, 64'h4000, 32'h0, 32'h0F0F0F0F, 2, 4, 1);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            int rd;
            int ad;
            rd = $urandom_range(0, 9);
            ad = rd + $urandom_range(0, 2);
            run_txn(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, $urandom,
                    rd, ad, bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        check("pready_pulse_count", pulses, n_txn);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
